vm_change_ctrl: RTL and testbench

- Sequencer between the vending-machine FSM and the physical product and coin dispensers.
- Accepts one vend/return request per transaction and drives the product motor with a handshake.
- Pays out the change as individual 10tk and 5tk coins from tracked inventories (10tk first), with a handshake per coin.
- Reports shortfall when the inventory cannot cover the change, and latches a fault if a dispenser stops acknowledging.

---
 rtl/vm_change_ctrl.sv | 132 +++++++++++++
 tb/tb_vm_change_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vm_change_ctrl.sv
// Vend/change sequencer: drives the product motor, then pays out change as
// 10tk/5tk coins from tracked inventories, with per-strobe ack timeout.
module vm_change_ctrl #(
  parameter int INV_W       = 4,
  parameter int INV5_INIT   = 8,
  parameter int INV10_INIT  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_purchase,
  input  logic [1:0]       req_return,
  output logic             vend,
  input  logic             vend_ack,
  output logic             drop5,
  output logic             drop10,
  input  logic             coin_ack,
  input  logic             refill5,
  input  logic             refill10,
  output logic [INV_W-1:0] inv5,
  output logic [INV_W-1:0] inv10,
  output logic             done,
  output logic             short,
  output logic [1:0]       short_amt,
  output logic             fault
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VEND, S_CHG, S_DROP, S_FIN, S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       rem;
  logic             sel10;
  logic [TMO_W-1:0] tmo;
  logic             accept, ack_now, tmo_hit, pay10, pay5;
  logic             used5, used10;

  // Refill and dispense of the same coin in one cycle cancel out.
  function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cur,
                                                input logic inc, input logic dec);
    if (inc && !dec)
      return (cur == {INV_W{1'b1}}) ? cur : cur + INV_W'(1);
    else if (dec && !inc)
      return cur - INV_W'(1);
    return cur;
  endfunction

  assign accept  = (state == S_IDLE) && req_valid;
  assign ack_now = ((state == S_VEND) && vend_ack) || ((state == S_DROP) && coin_ack);
  assign tmo_hit = (tmo == TMO_W'(ACK_TIMEOUT - 1));
  assign pay10   = (rem >= 2'd2) && (inv10 != '0);
  assign pay5    = (rem != 2'd0) && (inv5 != '0);
  assign used10  = (state == S_DROP) && coin_ack && sel10;
  assign used5   = (state == S_DROP) && coin_ack && !sel10;

  assign req_ready = (state == S_IDLE);
  assign vend      = (state == S_VEND);
  assign drop10    = (state == S_DROP) && sel10;
  assign drop5     = (state == S_DROP) && !sel10;
  assign done      = (state == S_FIN);
  assign fault     = (state == S_FAULT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:         if (req_valid) state_nxt = req_purchase ? S_VEND : S_CHG;
      S_VEND, S_DROP: begin
        if (ack_now)      state_nxt = S_CHG;
        else if (tmo_hit) state_nxt = S_FAULT;
      end
      S_CHG:          state_nxt = (pay10 || pay5) ? S_DROP : S_FIN;
      S_FIN:          state_nxt = S_IDLE;
      S_FAULT:        state_nxt = S_FAULT;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Counter is zero in every other state, so each strobe starts from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      tmo <= '0;
    else if ((state == S_VEND) || (state == S_DROP))
      tmo <= tmo + TMO_W'(1);
    else
      tmo <= '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      sel10     <= 1'b0;
      short     <= 1'b0;
      short_amt <= '0;
    end else begin
      if (accept) begin
        rem       <= req_return;
        short     <= 1'b0;
        short_amt <= '0;
      end
      if (state == S_CHG) begin
        sel10 <= pay10;
        if (!pay10 && !pay5 && (rem != 2'd0)) begin
          short     <= 1'b1;
          short_amt <= rem;
        end
      end
      if ((state == S_DROP) && coin_ack)
        rem <= rem - (sel10 ? 2'd2 : 2'd1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inv5  <= INV_W'(INV5_INIT);
      inv10 <= INV_W'(INV10_INIT);
    end else begin
      inv5  <= inv_next(inv5, refill5, used5);
      inv10 <= inv_next(inv10, refill10, used10);
    end
  end

endmodule

// File: tb/tb_vm_change_ctrl.sv
// Scoreboard bench for vm_change_ctrl: expected strobe/done events are queued
// per transaction and popped as the DUT raises them.
module tb_vm_change_ctrl;

  localparam int INV_W = 4;
  localparam int INV_MAX = (1 << INV_W) - 1;
  localparam int EV_VEND = 1, EV_D10 = 2, EV_D5 = 3, EV_DONE = 4;

  logic             clock = 1'b0, reset = 1'b0;
  logic             req_valid = 1'b0, req_ready, req_purchase = 1'b0;
  logic [1:0]       req_return = 2'd0;
  logic             vend, vend_ack = 1'b0;
  logic             drop5, drop10, coin_ack = 1'b0;
  logic             refill5 = 1'b0, refill10;
  logic             refill10_man = 1'b0, refill10_auto = 1'b0;
  logic [INV_W-1:0] inv5, inv10;
  logic             done, short, fault;
  logic [1:0]       short_amt;

  assign refill10 = refill10_man | refill10_auto;

  vm_change_ctrl #(.INV_W(INV_W), .INV5_INIT(8), .INV10_INIT(4), .ACK_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_purchase(req_purchase), .req_return(req_return), .vend(vend), .vend_ack(vend_ack),
    .drop5(drop5), .drop10(drop10), .coin_ack(coin_ack), .refill5(refill5),
    .refill10(refill10), .inv5(inv5), .inv10(inv10), .done(done), .short(short),
    .short_amt(short_amt), .fault(fault)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;
  int exp_q[$];
  int m5 = 8, m10 = 4;
  int vend_dly = 1, coin_dly = 1;
  bit coin_en = 1'b1, refill_on_ack10 = 1'b0;
  int vend_hi = 0, d10_hi = 0;
  int vc = 0, cc = 0;
  logic pv = 1'b0, p10 = 1'b0, p5 = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic expect_ev(input string tag, input int ev);
    if (exp_q.size() == 0) check(tag, ev, 0);
    else check(tag, ev, exp_q.pop_front());
  endtask

  // Monitor: pops the scoreboard on each strobe rising edge and on done.
  initial forever begin
    @(negedge clock);
    if (vend && !pv) begin vend_hi = 0; expect_ev("ev_vend", EV_VEND); end
    if (vend) vend_hi++;
    if (drop10 && !p10) begin d10_hi = 0; expect_ev("ev_drop10", EV_D10); end
    if (drop10) d10_hi++;
    if (drop5 && !p5) expect_ev("ev_drop5", EV_D5);
    if ((drop10 && !p10) || (drop5 && !p5)) check("drop_excl", int'(drop5 & drop10), 0);
    if (done) expect_ev("ev_done", EV_DONE);
    pv = vend; p10 = drop10; p5 = drop5;
  end

  // Dispenser model: acks after a programmable number of strobe cycles.
  initial forever begin
    @(negedge clock);
    vc = vend ? vc + 1 : 0;
    cc = (drop5 || drop10) ? cc + 1 : 0;
    vend_ack = vend && (vc == vend_dly);
    coin_ack = coin_en && (drop5 || drop10) && (cc == coin_dly);
    refill10_auto = refill_on_ack10 && coin_ack && drop10;
  end

  task automatic run_txn(input bit p, input bit [1:0] r);
    int rem = r;
    int cyc = 0;
    if (p) exp_q.push_back(EV_VEND);
    forever begin
      if (rem >= 2 && m10 > 0) begin
        exp_q.push_back(EV_D10); m10--; rem -= 2;
        if (refill_on_ack10 && m10 < INV_MAX) m10++;
      end else if (rem >= 1 && m5 > 0) begin
        exp_q.push_back(EV_D5); m5--; rem -= 1;
      end else break;
    end
    exp_q.push_back(EV_DONE);
    @(negedge clock);
    req_valid = 1'b1; req_purchase = p; req_return = r;
    @(negedge clock);
    req_valid = 1'b0; req_purchase = ~p; req_return = ~r;
    #1;
    while (!done && cyc < 200) begin @(negedge clock); #1; cyc++; end
    check("txn_done", int'(done), 1);
    check("short", int'(short), int'(rem != 0));
    check("short_amt", int'(short_amt), rem);
    check("inv5", int'(inv5), m5);
    check("inv10", int'(inv10), m10);
    check("q_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_refill(input bit ten, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (ten) begin refill10_man = 1'b1; if (m10 < INV_MAX) m10++; end
      else     begin refill5 = 1'b1;      if (m5 < INV_MAX) m5++;   end
    end
    @(negedge clock);
    refill10_man = 1'b0; refill5 = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_inv5", int'(inv5), 8);
    check("rst_inv10", int'(inv10), 4);
    check("rst_ready", int'(req_ready), 1);
    check("rst_strobes", int'({vend, drop5, drop10, done}), 0);
    check("rst_flags", int'({short, short_amt, fault}), 0);
    reset = 1'b1;

    vend_dly = 3;
    run_txn(1'b1, 2'd0);
    check("vend_cycles", vend_hi, 3);
    vend_dly = 1;

    run_txn(1'b1, 2'd3);

    for (int i = 0; i < 4; i++) begin
      coin_dly = 1 + (i % 3);
      run_txn(1'b0, 2'd2);
    end
    coin_dly = 1;
    check("inv10_drained", int'(inv10), 0);
    run_txn(1'b0, 2'd3);
    run_txn(1'b0, 2'd1);
    check("inv5_one", int'(inv5), 1);

    run_txn(1'b0, 2'd2);
    repeat (3) @(negedge clock);
    check("short_sticky", int'(short), 1);
    check("short_amt_sticky", int'(short_amt), 1);
    run_txn(1'b0, 2'd0);

    do_refill(1'b1, 4);
    check("refill10", int'(inv10), 4);
    refill_on_ack10 = 1'b1;
    run_txn(1'b0, 2'd2);
    refill_on_ack10 = 1'b0;
    do_refill(1'b0, 15);
    check("refill5_full", int'(inv5), 15);
    do_refill(1'b0, 1);
    check("refill5_sat", int'(inv5), 15);

    coin_en = 1'b0;
    exp_q.push_back(EV_D10);
    @(negedge clock);
    req_valid = 1'b1; req_purchase = 1'b0; req_return = 2'd2;
    @(negedge clock);
    req_valid = 1'b0;
    for (int i = 0; i < 100 && !fault; i++) @(negedge clock);
    #1;
    check("fault", int'(fault), 1);
    check("fault_drop_cycles", d10_hi, 15);
    check("fault_strobes", int'({vend, drop5, drop10, done}), 0);
    check("fault_ready", int'(req_ready), 0);
    check("fault_q_empty", exp_q.size(), 0);
    do_refill(1'b1, 1);
    check("fault_refill10", int'(inv10), m10);
    repeat (3) @(negedge clock);
    check("fault_sticky", int'(fault), 1);

    reset = 1'b0;
    #1;
    check("rerst_inv5", int'(inv5), 8);
    check("rerst_inv10", int'(inv10), 4);
    check("rerst_fault", int'(fault), 0);
    check("rerst_ready", int'(req_ready), 1);
    exp_q.delete();
    coin_en = 1'b1;
    m5 = 8; m10 = 4;
    @(negedge clock);
    reset = 1'b1;
    run_txn(1'b1, 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
